hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
Sequences multi-cycle MULT/MULTU/DIV/DIVU operations and owns the hi/lo write path (hl_write_enable_from_wb / hl_data) into the ID-stage register file. It accepts one operation from EX, holds the pipeline stall while the operation runs, and writes the 64-bit {hi,lo} result in a single one-cycle pulse. The cancel input aborts the operation on an exception or flush so that hi/lo are never written.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits.
MUL_LAT, 2, multiply cycles in state MUL; legal range is >= 1.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  operation request from EX; ignored unless the state is IDLE
op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a  in  WIDTH  rs operand (multiplicand or dividend)
src_b  in  WIDTH  rt operand (multiplier or divisor)
cancel  in  1  abort from exception or flush
busy  out  1  stall request to the pipeline hazard unit
hl_we  out  1  hi/lo write enable; drives the register file hl_write_enable_from_wb
hl_data  out  2*WIDTH  {hi,lo} result

Behaviour:
- Reset: state=IDLE, busy=0, hl_we=0, hl_data=0, all internal registers cleared. Reset in any state discards the in-flight operation and no write occurs.
- Accept: an operation is accepted in cycle T when state==IDLE, start=1 and cancel=0. src_a, src_b and op are captured at the T edge. start in any other state is ignored, with no queuing.
- States: IDLE, MUL, DIV, FIX, DONE.
  - IDLE -> MUL on an accepted MULT/MULTU.
  - IDLE -> DIV on an accepted DIV/DIVU with src_b!=0.
  - IDLE -> DONE on an accepted divide with src_b==0.
  - MUL: the full 2*WIDTH product is registered and a counter runs MUL_LAT cycles, then -> DONE.
  - DIV: restoring radix-2 on operand magnitudes, one quotient bit per cycle, WIDTH cycles, then -> FIX.
  - FIX: one cycle of sign correction, then -> DONE.
  - DONE: one cycle, then -> IDLE.
- Latency measured from the accept cycle T:
  - multiply: hl_we at T+MUL_LAT+1
  - divide: hl_we at T+WIDTH+2, i.e. T+34 at default width
  - divide by zero: hl_we at T+1
- busy=1 whenever state!=IDLE, including the DONE cycle. busy=0 in the accept cycle itself; the hazard unit stalls on start.
- hl_we = (state==DONE) & ~cancel. hl_data is valid and stable for the whole DONE cycle and holds its value afterwards.
- Arithmetic rules:
  - MULT is a signed WIDTH x WIDTH -> 2*WIDTH product; MULTU is unsigned.
  - DIV is signed. Quotient is negative iff operand signs differ; remainder takes the dividend's sign. hi=remainder, lo=quotient.
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0. This is the natural wrap with no trap.
  - Divide by zero (either signedness) gives hi=src_a, lo=all-ones.
- Cancel:
  - In MUL, DIV or FIX: the next state is IDLE, busy drops the following cycle, no write.
  - In DONE: hl_we is suppressed and the next state is IDLE.
  - cancel together with start in IDLE: nothing is accepted.
- rst takes priority over cancel, and cancel takes priority over start.

Decomposition:
- Shared package: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encoding, and the divide-by-zero lo constant.
- One sub-module: hilo_div_core, the iterative restoring divider datapath. Its interface is load/step inputs, magnitude operands in, and quotient/remainder out.
- The FSM, the multiply register and the sign fix stay in the top module.

Test Plan:
1. MULT a=0xFFFFFFFF, b=0x00000002, MUL_LAT=2, accept at T -> hl_we at T+3, hl_data=0xFFFFFFFF_FFFFFFFE; busy high T+1..T+3.
2. MULTU with the same operands -> hl_data=0x00000001_FFFFFFFE. DIVU a=100, b=7 -> hl_we at T+34, hi=0x00000002, lo=0x0000000E.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD. DIV a=0x80000000, b=0xFFFFFFFF -> hi=0, lo=0x80000000.
4. DIV a=0x12345678, b=0 -> hl_we at T+1, hi=0x12345678, lo=0xFFFFFFFF.
5. Cancel and start interaction:
   - Start DIVU, then cancel at T+10 -> busy=0 from T+11, hl_we never asserted.
   - A second start at T+5 during the operation is ignored, and the first result is unchanged.
6. Reset and DONE-cycle cancel:
   - rst pulsed in DIV -> next cycle state IDLE, busy=0, hl_data=0, no hl_we.
   - cancel asserted exactly in the DONE cycle -> hl_we=0.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// rtl/hilo_muldiv_ctrl_pkg.sv - shared encodings for the hi/lo multiply/divide sequencer
//
// Purpose: operation codes, FSM state encoding and the divide-by-zero lo
//          constant shared by hilo_muldiv_ctrl and its divider datapath.
// Ports:   none (package)

package hilo_muldiv_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // Divide by zero returns lo = all ones; sliced to WIDTH by the user.
   localparam int              DIV0_MAX_W = 64;
   localparam logic [DIV0_MAX_W-1:0] DIV0_LO = '1;

endpackage

// File: rtl/hilo_div_core.sv
// rtl/hilo_div_core.sv - iterative restoring radix-2 divider on unsigned magnitudes
//
// Purpose: produces one quotient bit per step; after WIDTH steps quotient and
//          remainder hold the unsigned result of dividend / divisor.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load                capture dividend/divisor and clear the partial remainder
//   step                perform one restoring iteration
//   dividend, divisor   unsigned magnitudes (divisor must be non-zero)
//   quotient, remainder result after WIDTH steps

module hilo_div_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;   // dividend bits shift out the top, quotient bits in at the bottom
   logic [WIDTH-1:0] dsr_q;
   logic [WIDTH:0]   trial;

   // Shifted partial remainder minus divisor; MSB set means the subtraction underflowed.
   assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dsr_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         dsr_q <= divisor;
      end else if (step) begin
         if (trial[WIDTH]) begin
            rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
         end else begin
            rem_q <= trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - MULT/MULTU/DIV/DIVU sequencer owning the hi/lo write path
//
// Purpose: accepts one operation from EX, stalls the pipeline while it runs and
//          writes {hi,lo} with a single one-cycle hl_we pulse; cancel aborts it.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start, op     operation request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   src_a, src_b  rs / rt operands
//   cancel        exception/flush abort
//   busy          stall request (high whenever not idle)
//   hl_we         hi/lo register file write enable
//   hl_data       {hi,lo} result

module hilo_muldiv_ctrl
   import hilo_muldiv_ctrl_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   src_a,
   input  logic [WIDTH-1:0]   src_b,
   input  logic               cancel,
   output logic               busy,
   output logic               hl_we,
   output logic [2*WIDTH-1:0] hl_data
);

   localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   state_e state, state_nxt;

   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] prod_q;
   logic               q_neg, r_neg;

   logic               accept, is_mul, is_div, is_sdiv, div_by_zero;
   logic               mul_last, div_last;
   logic [2*WIDTH-1:0] prod_s, prod_u;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH-1:0]   quo_mag, rem_mag, quo_fix, rem_fix;

   assign accept      = (state == ST_IDLE) && start && !cancel;
   assign is_mul      = (op == OP_MULT) || (op == OP_MULTU);
   assign is_div      = !is_mul;
   assign is_sdiv     = (op == OP_DIV);
   assign div_by_zero = is_div && (src_b == '0);
   assign mul_last    = (state == ST_MUL) && (cnt == CNT_W'(MUL_LAT - 1));
   assign div_last    = (state == ST_DIV) && (cnt == CNT_W'(WIDTH - 1));

   // Both products are taken at full 2*WIDTH; sign extension makes the low
   // 2*WIDTH bits of the unsigned multiply equal the signed product.
   assign prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
   assign prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

   // Signed divide runs on magnitudes; the most negative value maps to itself,
   // which is its correct unsigned magnitude.
   assign a_mag = (is_sdiv && src_a[WIDTH-1]) ? -src_a : src_a;
   assign b_mag = (is_sdiv && src_b[WIDTH-1]) ? -src_b : src_b;

   hilo_div_core #(.WIDTH(WIDTH)) u_div_core (
      .clk       (clk),
      .rst       (rst),
      .load      (accept && is_div),
      .step      (state == ST_DIV),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (quo_mag),
      .remainder (rem_mag)
   );

   assign quo_fix = q_neg ? -quo_mag : quo_mag;
   assign rem_fix = r_neg ? -rem_mag : rem_mag;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (is_mul)           state_nxt = ST_MUL;
               else if (div_by_zero) state_nxt = ST_DONE;
               else                  state_nxt = ST_DIV;
            end
         end
         ST_MUL: begin
            if (cancel)        state_nxt = ST_IDLE;
            else if (mul_last) state_nxt = ST_DONE;
         end
         ST_DIV: begin
            if (cancel)        state_nxt = ST_IDLE;
            else if (div_last) state_nxt = ST_FIX;
         end
         ST_FIX: begin
            if (cancel) state_nxt = ST_IDLE;
            else        state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      busy  = (state != ST_IDLE);
      hl_we = (state == ST_DONE) && !cancel;
   end

   // Datapath registers: counter, product, sign flags and the result holding register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         prod_q  <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
         hl_data <= '0;
      end else begin
         if (accept) begin
            cnt    <= '0;
            prod_q <= (op == OP_MULT) ? prod_s : prod_u;
            q_neg  <= is_sdiv && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            r_neg  <= is_sdiv && src_a[WIDTH-1];
            if (div_by_zero)
               hl_data <= {src_a, DIV0_LO[WIDTH-1:0]};
         end else if ((state == ST_MUL) || (state == ST_DIV)) begin
            cnt <= cnt + 1'b1;
         end

         if (mul_last && !cancel)
            hl_data <= prod_q;
         if ((state == ST_FIX) && !cancel)
            hl_data <= {rem_fix, quo_fix};
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - directed self-checking bench for hilo_muldiv_ctrl

module tb_hilo_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a, src_b;
   logic        cancel;
   logic        busy, hl_we;
   logic [63:0] hl_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hilo_muldiv_ctrl #(.WIDTH(32), .MUL_LAT(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .src_a   (src_a),
      .src_b   (src_b),
      .cancel  (cancel),
      .busy    (busy),
      .hl_we   (hl_we),
      .hl_data (hl_data)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one operation at cycle T, optionally pulse a second (ignored) start
   // at T+extra_at, then check latency, busy coverage and the written result.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [63:0] exp,
                         input int extra_at);
      int k;
      bit seen, busy_ok;
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      #1 check({tag, "_busy_T"}, busy, 1'b0);
      k = 0; seen = 0; busy_ok = 1;
      while (!seen && k < 100) begin
         @(negedge clk);
         start = 1'b0;
         k++;
         if (!busy) busy_ok = 0;
         if (hl_we) seen = 1;
         else if (k == extra_at) begin
            start = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd5;
         end
      end
      check({tag, "_lat"}, 64'(k), 64'(lat));
      check({tag, "_busy"}, busy_ok, 1'b1);
      check({tag, "_data"}, hl_data, exp);
      @(negedge clk);
      check({tag, "_after"}, {busy, hl_we}, 2'b00);
      check({tag, "_hold"}, hl_data, exp);
   endtask

   // Watch for n cycles; any hl_we is an error.
   task automatic no_write(input string tag, input int n);
      bit wrote = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (hl_we) wrote = 1;
      end
      check(tag, wrote, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; cancel = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outs", {busy, hl_we}, 2'b00);
      check("reset_data", hl_data, 64'h0);
      rst = 1'b0;

      run_op("mult",     2'b00, 32'hFFFFFFFF, 32'h00000002, 3,  64'hFFFFFFFF_FFFFFFFE, 0);
      run_op("multu",    2'b01, 32'hFFFFFFFF, 32'h00000002, 3,  64'h00000001_FFFFFFFE, 0);
      run_op("mult_min", 2'b00, 32'h80000000, 32'h80000000, 3,  64'h40000000_00000000, 0);
      run_op("divu",     2'b11, 32'd100,      32'd7,        34, 64'h00000002_0000000E, 0);
      run_op("div_neg",  2'b10, 32'hFFFFFFF9, 32'h00000002, 34, 64'hFFFFFFFF_FFFFFFFD, 0);
      run_op("div_ovf",  2'b10, 32'h80000000, 32'hFFFFFFFF, 34, 64'h00000000_80000000, 0);
      run_op("div_mix",  2'b10, 32'd100,      32'hFFFFFFF9, 34, 64'h00000002_FFFFFFF2, 0);
      run_op("div0",     2'b10, 32'h12345678, 32'h0,        1,  64'h12345678_FFFFFFFF, 0);
      run_op("divu0",    2'b11, 32'hCAFEF00D, 32'h0,        1,  64'hCAFEF00D_FFFFFFFF, 0);
      run_op("ign_start",2'b11, 32'd100,      32'd7,        34, 64'h00000002_0000000E, 5);

      // Cancel in DIV at T+10: busy drops at T+11, no write ever.
      @(negedge clk);
      start = 1'b1; op = 2'b11; src_a = 32'd1000; src_b = 32'd3;
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      cancel = 1'b1;
      #1 check("cancel_busy_T10", busy, 1'b1);
      check("cancel_we_T10", hl_we, 1'b0);
      @(negedge clk); cancel = 1'b0;
      check("cancel_busy_T11", busy, 1'b0);
      no_write("cancel_no_we", 40);

      // cancel together with start in IDLE accepts nothing.
      @(negedge clk);
      start = 1'b1; cancel = 1'b1; op = 2'b00; src_a = 32'd2; src_b = 32'd3;
      @(negedge clk); start = 1'b0; cancel = 1'b0;
      check("cancel_start_idle", busy, 1'b0);
      no_write("cancel_start_no_we", 6);

      // Reset during DIV discards the operation and clears hl_data.
      @(negedge clk);
      start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check("rst_div_outs", {busy, hl_we}, 2'b00);
      check("rst_div_data", hl_data, 64'h0);
      no_write("rst_div_no_we", 40);

      // Cancel exactly in the DONE cycle suppresses hl_we.
      @(negedge clk);
      start = 1'b1; op = 2'b10; src_a = 32'h12345678; src_b = 32'h0;
      @(negedge clk); start = 1'b0; cancel = 1'b1;
      #1 check("done_cancel_we", hl_we, 1'b0);
      check("done_cancel_busy", busy, 1'b1);
      @(negedge clk); cancel = 1'b0;
      check("done_cancel_after", {busy, hl_we}, 2'b00);

      // Cancel in DONE of a multiply as well.
      @(negedge clk);
      start = 1'b1; op = 2'b01; src_a = 32'd6; src_b = 32'd7;
      @(negedge clk); start = 1'b0;
      @(negedge clk); @(negedge clk); cancel = 1'b1;
      #1 check("mul_done_cancel_busy", busy, 1'b1);
      check("mul_done_cancel_we", hl_we, 1'b0);
      @(negedge clk); cancel = 1'b0;
      check("mul_done_cancel_after", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
